// File: rtl/pmu_counters_if.sv
// pmu_counters_if
// Groups the control, write-port and status signals of the counter bank.
// Port summary:
//   softrst_i        synchronous soft reset, active-high
//   en_i             global count enable
//   events_i         one event pulse line per counter
//   we_i/waddr_i/wdata_i  software preload port
//   overflow_mask_i  selects which sticky overflow flags raise the interrupt
//   counter_value_o  current value of every counter
//   overflow_o       sticky per-counter overflow flags
//   intr_overflow_o  masked OR of the overflow flags
// The master modport drives the inputs (config/monitor side); the slave
// modport is the counter bank itself.
interface pmu_counters_if #(
  parameter int REG_WIDTH  = 32,
  parameter int N_COUNTERS = 9
);
  localparam int AW = (N_COUNTERS > 1) ? $clog2(N_COUNTERS) : 1;

  logic                  softrst_i;
  logic                  en_i;
  logic [N_COUNTERS-1:0] events_i;
  logic                  we_i;
  logic [AW-1:0]         waddr_i;
  logic [REG_WIDTH-1:0]  wdata_i;
  logic [N_COUNTERS-1:0] overflow_mask_i;
  logic [REG_WIDTH-1:0]  counter_value_o [N_COUNTERS];
  logic [N_COUNTERS-1:0] overflow_o;
  logic                  intr_overflow_o;

  modport master (
    output softrst_i, en_i, events_i, we_i, waddr_i, wdata_i, overflow_mask_i,
    input  counter_value_o, overflow_o, intr_overflow_o
  );

  modport slave (
    input  softrst_i, en_i, events_i, we_i, waddr_i, wdata_i, overflow_mask_i,
    output counter_value_o, overflow_o, intr_overflow_o
  );
endinterface

// File: rtl/pmu_counters.sv
// pmu_counters
// Bank of N_COUNTERS free-running event counters with a software preload
// port, sticky per-counter overflow flags and a masked overflow interrupt.
// Ports:
//   clk_i   single clock
//   rstn_i  asynchronous active-low reset
//   bus     pmu_counters_if slave modport (control, write port, status)
// Events are registered once (gated by en_i) before reaching the counters,
// so an event sampled at edge k shows up in the counter after edge k+1.
module pmu_counters #(
  parameter int REG_WIDTH  = 32,
  parameter int N_COUNTERS = 9
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  pmu_counters_if.slave   bus
);
  localparam int AW = (N_COUNTERS > 1) ? $clog2(N_COUNTERS) : 1;

  logic [N_COUNTERS-1:0] events_q;
  logic [REG_WIDTH-1:0]  count_q [N_COUNTERS];
  logic [N_COUNTERS-1:0] overflow_q;

  // Event capture stage. en_i is sampled alongside the event, so an event
  // already captured here still counts even if en_i drops afterwards.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      events_q <= '0;
    end else if (bus.softrst_i) begin
      events_q <= '0;
    end else begin
      events_q <= bus.events_i & {N_COUNTERS{bus.en_i}};
    end
  end

  // Counter update. A write to a counter takes precedence over its pending
  // event, which is dropped. Write addresses beyond the bank never match any
  // index, so they leave every counter untouched. Wrapping from all-ones
  // raises the sticky flag on the same edge the counter returns to zero.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int n = 0; n < N_COUNTERS; n++) begin
        count_q[n] <= '0;
      end
      overflow_q <= '0;
    end else if (bus.softrst_i) begin
      for (int n = 0; n < N_COUNTERS; n++) begin
        count_q[n] <= '0;
      end
      overflow_q <= '0;
    end else begin
      for (int n = 0; n < N_COUNTERS; n++) begin
        if (bus.we_i && (bus.waddr_i == AW'(n))) begin
          count_q[n]    <= bus.wdata_i;
          overflow_q[n] <= 1'b0;
        end else if (events_q[n]) begin
          count_q[n] <= count_q[n] + REG_WIDTH'(1);
          if (&count_q[n]) begin
            overflow_q[n] <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.counter_value_o = count_q;
  assign bus.overflow_o      = overflow_q;

  // Mask changes act immediately and never touch the flags themselves.
  assign bus.intr_overflow_o = |(overflow_q & bus.overflow_mask_i);
endmodule
